mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Two-master, one-slave arbiter for the native valid/ready memory bus. It sits between the CPU (m0)
//  and a second bus master (m1, e.g. a DMA/blitter) and the shared chip-select/ready/rdata fabric.
//  It grants one master at a time with round-robin fairness and holds the grant for a whole
//  transaction. A watchdog terminates stalled transfers with an error response.
// PARAMETERS
//  ADDR_WIDTH  32            address width of all buses
//  DATA_WIDTH  32            data width (wstrb width = DATA_WIDTH/8)
//  TIMEOUT     255           max granted cycles without s_ready; 0 disables the watchdog
//  ERR_DATA    32'hDEADBEEF  rdata returned on a timed-out transfer
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst_n        in   1   asynchronous active-low reset
//  m0_valid     in   1   master 0 request (CPU); m0_addr/m0_wdata/m0_wstrb in, same widths as s_*
//  m0_ready     out  1   master 0 transfer complete
//  m0_rdata     out  DW  master 0 read data
//  m1_valid     in   1   master 1 request; m1_addr/m1_wdata/m1_wstrb in, as m0
//  m1_ready     out  1   master 1 transfer complete
//  m1_rdata     out  DW  master 1 read data
//  s_valid      out  1   request to slave fabric; s_addr/s_wdata/s_wstrb out, muxed from granted master
//  s_ready      in   1   slave transfer complete
//  s_rdata      in   DW  slave read data
//  grant        out  2   one-hot current owner {m1,m0}; 00 when idle
//  timeout_err  out  1   one-cycle pulse on watchdog expiry
// BEHAVIOUR
//  - States: IDLE, GNT0, GNT1, ERR. Registers: state, last (last served master), wd_cnt.
//  - Reset: state=IDLE, last=1 (so m0 wins the first tie), wd_cnt=0. All outputs are 0 in IDLE,
//    including s_addr, s_wdata, s_wstrb, m*_rdata and grant.
//  - IDLE: arbitration uses registered grant. If one master is valid, grant it. If both are valid,
//    grant the master != last. The new state applies at the next edge.
//    Latency: master valid at cycle T gives s_valid at T+1.
//  - GNTn: s_valid=mn_valid; s_addr/s_wdata/s_wstrb=mn_*; mn_ready=s_ready (combinational);
//    mn_rdata=s_rdata. The other master sees ready=0 and rdata=0.
//  - Completion (GNTn & s_ready): last<=n, wd_cnt<=0. If the other master is valid, go straight to
//    its GNT state with no bubble; else go IDLE. The same master never gets two consecutive grants
//    while the other is waiting.
//  - Master drops valid while granted (abort): s_valid falls the same cycle. Next state is IDLE,
//    last<=n, no ready is issued. A same-cycle s_ready is ignored (s_valid is already 0).
//  - Watchdog (TIMEOUT>0): wd_cnt increments each GNT cycle without s_ready.
//    If wd_cnt==TIMEOUT-1 and !s_ready, go to ERR. So s_valid is high exactly TIMEOUT cycles.
//    wd_cnt width = clog2(TIMEOUT+1), and it never wraps.
//  - ERR (1 cycle): s_valid=0; mn_ready=1 and mn_rdata=ERR_DATA for the timed-out master n;
//    timeout_err=1; grant keeps n. Exit follows the completion rules.
//  - TIMEOUT=0: wd_cnt is held at 0 and ERR is unreachable.
//  - Writes (wstrb!=0) and reads share the identical flow; the arbiter never inspects wstrb.
//  - rst_n low mid-transfer: async return to reset values; s_valid and m*_ready drop immediately.
// TESTING
//  1. m0_valid=1 at cycle 0, s_ready=1 at cycle 3, s_rdata=0x12345678 -> s_valid cycles 1-3,
//     m0_ready=1 only in cycle 3, m0_rdata=0x12345678, grant=01 cycles 1-3, then IDLE.
//  2. After reset, both valid at cycle 0, slave ready after 1 cycle -> grant 01 (m0 first), then
//     10 with no idle cycle, then 01. Strict alternation over 8 transfers.
//  3. TIMEOUT=4, m1 read, s_ready stuck 0 -> s_valid cycles 1-4; cycle 5: m1_ready=1,
//     m1_rdata=0xDEADBEEF, timeout_err=1, s_valid=0; then IDLE.
//  4. m0 granted, m0_valid dropped in cycle 2 while m1 waits -> no m0_ready, IDLE in cycle 3,
//     m1 granted next edge (s_valid cycle 4).
//  5. m1 write wstrb=0011, addr=0x5000, wdata=0xBEEF -> s_addr=0x5000, s_wstrb=0011,
//     s_wdata=0xBEEF while granted; m0 ports unaffected.
//  6. rst_n pulsed low mid-GNT0 -> s_valid, m0_ready and grant go 0 asynchronously; after release,
//     the first tie goes to m0.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Native valid/ready memory bus. A requester drives valid/addr/wdata/wstrb and
// waits for ready; the responder returns ready and rdata in the completing cycle.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                      valid;
  logic [ADDR_WIDTH-1:0]     addr;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   wstrb;
  logic                      ready;
  logic [DATA_WIDTH-1:0]     rdata;

  // Side that issues requests.
  modport master (
    output valid, addr, wdata, wstrb,
    input  ready, rdata
  );

  // Side that answers requests.
  modport slave (
    input  valid, addr, wdata, wstrb,
    output ready, rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master / one-slave arbiter for the native memory bus.
// Round-robin between m0 (CPU) and m1 (DMA), grant held for a whole transfer,
// back-to-back hand-over when the other master is waiting, and a watchdog that
// answers a stalled transfer with ERR_DATA and a one-cycle timeout_err pulse.
module mem_arbiter #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    TIMEOUT    = 255,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA   = 32'hDEADBEEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_arbiter_if.slave         m0,
  mem_arbiter_if.slave         m1,
  mem_arbiter_if.master        s,
  output logic [1:0]           grant,
  output logic                 timeout_err
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  // Watchdog counter only ever reaches TIMEOUT-1, so it can never wrap.
  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t          state_reg;
  logic [1:0]      grant_reg;        // one-hot owner, also held through ERR
  logic            last_reg;         // index of the master served last
  logic [WD_W-1:0] wd_cnt_reg;
  logic            timeout_err_reg;

  // Masters gathered into index-able arrays so both sides share one mux.
  logic [1:0]            req;
  logic [ADDR_WIDTH-1:0] mst_addr  [2];
  logic [DATA_WIDTH-1:0] mst_wdata [2];
  logic [STRB_WIDTH-1:0] mst_wstrb [2];
  logic [1:0]            rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata [2];

  assign req          = {m1.valid, m0.valid};
  assign mst_addr[0]  = m0.addr;
  assign mst_addr[1]  = m1.addr;
  assign mst_wdata[0] = m0.wdata;
  assign mst_wdata[1] = m1.wdata;
  assign mst_wstrb[0] = m0.wstrb;
  assign mst_wstrb[1] = m1.wstrb;

  logic cur;      // index of the current owner (valid only when grant_reg != 0)
  logic in_gnt;   // a transfer is being presented to the slave
  assign cur    = grant_reg[1];
  assign in_gnt = (state_reg == GNT0) || (state_reg == GNT1);

  // Winner when leaving IDLE: the only requester, or on a tie the one not served last.
  logic idle_pick_next;
  assign idle_pick_next = (req == 2'b11) ? ~last_reg : req[1];

  // Where a finished (completed or timed-out) transfer goes: straight to the
  // other master if it is waiting, otherwise back to IDLE.
  state_t     hand_state_next;
  logic [1:0] hand_grant_next;
  always_comb begin
    hand_state_next = IDLE;
    hand_grant_next = 2'b00;
    if (req[~cur]) begin
      hand_state_next = cur ? GNT0 : GNT1;
      hand_grant_next = cur ? 2'b01 : 2'b10;
    end
  end

  // Arbitration FSM with watchdog; grant and timeout_err are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      grant_reg       <= 2'b00;
      last_reg        <= 1'b1;
      wd_cnt_reg      <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      timeout_err_reg <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          if (|req) begin
            state_reg <= idle_pick_next ? GNT1 : GNT0;
            grant_reg <= idle_pick_next ? 2'b10 : 2'b01;
          end
        end
        GNT0, GNT1: begin
          if (!req[cur]) begin
            // Owner withdrew: abandon the transfer without a ready.
            state_reg  <= IDLE;
            grant_reg  <= 2'b00;
            last_reg   <= cur;
            wd_cnt_reg <= '0;
          end else if (s.ready) begin
            state_reg  <= hand_state_next;
            grant_reg  <= hand_grant_next;
            last_reg   <= cur;
            wd_cnt_reg <= '0;
          end else if (TIMEOUT > 0) begin
            if (wd_cnt_reg == WD_LAST) begin
              state_reg       <= ERR;
              wd_cnt_reg      <= '0;
              timeout_err_reg <= 1'b1;
            end else begin
              wd_cnt_reg <= wd_cnt_reg + 1'b1;
            end
          end
        end
        ERR: begin
          state_reg  <= hand_state_next;
          grant_reg  <= hand_grant_next;
          last_reg   <= cur;
          wd_cnt_reg <= '0;
        end
        default: begin
          state_reg <= IDLE;
          grant_reg <= 2'b00;
        end
      endcase
    end
  end

  // Per-master response: live slave ready/rdata while owning the bus,
  // forced error answer in ERR, zero for the master not granted.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
      assign rsp_ready[gi] = grant_reg[gi] &
                             ((state_reg == ERR) | (in_gnt & req[gi] & s.ready));
      assign rsp_rdata[gi] = !grant_reg[gi]     ? '0       :
                             (state_reg == ERR) ? ERR_DATA :
                             in_gnt             ? s.rdata  : '0;
    end
  endgenerate

  assign m0.ready = rsp_ready[0];
  assign m1.ready = rsp_ready[1];
  assign m0.rdata = rsp_rdata[0];
  assign m1.rdata = rsp_rdata[1];

  // Slave request follows the owner's valid directly so an abort drops it at once.
  assign s.valid = in_gnt & req[cur];
  assign s.addr  = in_gnt ? mst_addr[cur]  : '0;
  assign s.wdata = in_gnt ? mst_wdata[cur] : '0;
  assign s.wstrb = in_gnt ? mst_wstrb[cur] : '0;

  assign grant       = grant_reg;
  assign timeout_err = timeout_err_reg;

endmodule
